ahb_arbiter: RTL and testbench

AHB_ARBITER -- requirements
Module: ahb_arbiter

---
 rtl/ahb_arbiter.sv | 172 +++++++++++++++++
 tb/tb_ahb_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_arbiter.sv
// AHB bus arbiter: round-robin grant among NUM_M masters. The grant is held
// across fixed-length bursts and locked sequences, master 0 is parked when
// nobody requests, and address/data-phase owner indices are produced for the
// bus muxes.
//
// Handshake: hready is the single bus-wide advance strobe. Each rising edge
// with hready=1 completes the current transfer, and the arbiter samples
// htrans/hburst/hresp/hbusreq/hlock on that edge. With hready=0 the bus is
// stalled, so every register holds. Reset is the only exception.
module ahb_arbiter #(
  parameter int NUM_M = 4,
  parameter int MW    = $clog2(NUM_M)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_M-1:0]  hbusreq,
  input  logic [NUM_M-1:0]  hlock,
  input  logic [1:0]        htrans,
  input  logic [2:0]        hburst,
  input  logic              hready,
  input  logic              hresp,
  output logic [NUM_M-1:0]  hgrant,
  output logic [MW-1:0]     hmaster,
  output logic [MW-1:0]     hmaster_d,
  output logic              hmastlock,
  output logic [1:0]        dbg_state,
  output logic [3:0]        dbg_cnt
);

  localparam logic [1:0] ST_PARK    = 2'd0;
  localparam logic [1:0] ST_GRANTED = 2'd1;
  localparam logic [1:0] ST_BURST   = 2'd2;
  localparam logic [1:0] ST_LOCKED  = 2'd3;

  localparam logic [1:0] TR_IDLE   = 2'd0;
  localparam logic [1:0] TR_BUSY   = 2'd1;
  localparam logic [1:0] TR_NONSEQ = 2'd2;
  localparam logic [1:0] TR_SEQ    = 2'd3;

  logic [1:0]       state, nxt_state;
  logic [3:0]       cnt, nxt_cnt;
  logic [MW-1:0]    ptr, nxt_ptr;
  logic [NUM_M-1:0] nxt_grant;

  logic [MW-1:0]    owner_idx;
  logic             arb_found;
  logic [MW-1:0]    arb_idx;
  logic [MW-1:0]    arb_ptr_next;
  logic             do_arb;
  logic             burst_start;
  logic [3:0]       burst_len;
  logic             is_seq;

  assign dbg_state = state;
  assign dbg_cnt   = cnt;
  assign is_seq    = (htrans == TR_SEQ);

  // Encode the one-hot grant register into the current owner's index.
  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (hgrant[i]) owner_idx = MW'(i);
    end
  end

  // Round-robin search: the first requester at or after ptr, wrapping.
  always_comb begin
    int idx;
    idx       = 0;
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int k = 0; k < NUM_M; k++) begin
      idx = (int'(ptr) + k) % NUM_M;
      if (!arb_found && hbusreq[idx]) begin
        arb_found = 1'b1;
        arb_idx   = MW'(idx);
      end
    end
    arb_ptr_next = (arb_idx == MW'(NUM_M - 1)) ? '0 : arb_idx + MW'(1);
  end

  // Detect the start of a fixed-length burst; the count excludes the NONSEQ beat.
  always_comb begin
    burst_len = 4'd0;
    case (hburst)
      3'd3:    burst_len = 4'd3;
      3'd5:    burst_len = 4'd7;
      3'd7:    burst_len = 4'd15;
      default: burst_len = 4'd0;
    endcase
    burst_start = (htrans == TR_NONSEQ) && (burst_len != 4'd0);
  end

  // Next-state, beat count and arbitration decision for an hready=1 edge.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_ptr   = ptr;
    nxt_grant = hgrant;
    do_arb    = 1'b0;

    case (state)
      ST_PARK: begin
        do_arb = 1'b1;
      end
      ST_GRANTED: begin
        if (burst_start) begin
          nxt_cnt   = burst_len;
          nxt_state = ST_BURST;
        end else if (!hbusreq[owner_idx]) begin
          do_arb = 1'b1;
        end
      end
      ST_BURST: begin
        if (hresp) begin
          // Error response aborts the burst; the owner drops back to GRANTED.
          nxt_cnt   = 4'd0;
          nxt_state = ST_GRANTED;
        end else if (is_seq) begin
          if (cnt != 4'd0) nxt_cnt = cnt - 4'd1;
          // Re-arbitrate one beat early so the new grant is seen during the
          // final address beat of the current burst.
          if (cnt == 4'd2) do_arb = 1'b1;
          if (cnt <= 4'd1) nxt_state = hlock[owner_idx] ? ST_LOCKED : ST_GRANTED;
        end
      end
      default: begin
        // Locked: hold the grant until the owner drops hlock outside a burst.
        if (!hlock[owner_idx] && (htrans != TR_SEQ) && (htrans != TR_BUSY)) begin
          do_arb = 1'b1;
        end else if (burst_start) begin
          nxt_cnt = burst_len;
        end else if (is_seq && (cnt != 4'd0)) begin
          nxt_cnt = cnt - 4'd1;
        end
      end
    endcase

    if (do_arb) begin
      if (arb_found) begin
        nxt_grant = NUM_M'(1) << arb_idx;
        nxt_ptr   = arb_ptr_next;
        if (state != ST_BURST) nxt_state = hlock[arb_idx] ? ST_LOCKED : ST_GRANTED;
      end else begin
        nxt_grant = NUM_M'(1);
        if (state != ST_BURST) nxt_state = ST_PARK;
      end
    end
  end

  // Registered state: reset has priority, otherwise advance only when hready=1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_PARK;
      cnt       <= 4'd0;
      ptr       <= MW'(1);
      hgrant    <= NUM_M'(1);
      hmaster   <= '0;
      hmaster_d <= '0;
      hmastlock <= 1'b0;
    end else if (hready) begin
      state     <= nxt_state;
      cnt       <= nxt_cnt;
      ptr       <= nxt_ptr;
      hgrant    <= nxt_grant;
      hmaster   <= owner_idx;
      hmaster_d <= hmaster;
      hmastlock <= hlock[owner_idx];
    end
  end

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed testbench for ahb_arbiter (NUM_M=4) with hand-computed expectations.
module tb_ahb_arbiter;

  localparam int NUM_M = 4;
  localparam int MW    = 2;

  localparam logic [1:0] PARK    = 2'd0;
  localparam logic [1:0] GRANTED = 2'd1;
  localparam logic [1:0] BURST   = 2'd2;
  localparam logic [1:0] LOCKED  = 2'd3;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] NONSEQ = 2'd2;
  localparam logic [1:0] SEQ    = 2'd3;

  logic             clk = 1'b0;
  logic             rst;
  logic [NUM_M-1:0] hbusreq;
  logic [NUM_M-1:0] hlock;
  logic [1:0]       htrans;
  logic [2:0]       hburst;
  logic             hready;
  logic             hresp;
  logic [NUM_M-1:0] hgrant;
  logic [MW-1:0]    hmaster;
  logic [MW-1:0]    hmaster_d;
  logic             hmastlock;
  logic [1:0]       dbg_state;
  logic [3:0]       dbg_cnt;

  int n_cmp = 0;
  int n_err = 0;
  logic [NUM_M-1:0] exp_q[$];

  ahb_arbiter #(.NUM_M(NUM_M), .MW(MW)) dut (
    .clk(clk), .rst(rst), .hbusreq(hbusreq), .hlock(hlock),
    .htrans(htrans), .hburst(hburst), .hready(hready), .hresp(hresp),
    .hgrant(hgrant), .hmaster(hmaster), .hmaster_d(hmaster_d),
    .hmastlock(hmastlock), .dbg_state(dbg_state), .dbg_cnt(dbg_cnt)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Advance one edge; sample and redrive 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; hready = 1'b0; hbusreq = '0; hlock = '0;
    htrans = IDLE; hburst = 3'd0; hresp = 1'b0;
    step(); step();
    rst = 1'b0; hready = 1'b1;
  endtask

  initial begin
    logic [NUM_M-1:0] prev;
    logic [NUM_M-1:0] e;
    rst = 1'b1; hready = 1'b0; hbusreq = '0; hlock = '0;
    htrans = IDLE; hburst = 3'd0; hresp = 1'b0;

    // Reset state (hready held low during reset)
    do_reset();
    check("rst_hgrant", 32'(hgrant), 32'h1);
    check("rst_hmaster", 32'(hmaster), 32'h0);
    check("rst_hmaster_d", 32'(hmaster_d), 32'h0);
    check("rst_hmastlock", 32'(hmastlock), 32'h0);
    check("rst_cnt", 32'(dbg_cnt), 32'h0);
    check("rst_state", 32'(dbg_state), 32'(PARK));

    // Single request: grant, then hmaster, then hmaster_d
    hbusreq = 4'b0100;
    step();
    check("single_hgrant", 32'(hgrant), 32'h4);
    check("single_state", 32'(dbg_state), 32'(GRANTED));
    step();
    check("single_hmaster", 32'(hmaster), 32'd2);
    step();
    check("single_hmaster_d", 32'(hmaster_d), 32'd2);

    // No request parks on master 0 and leaves ptr at 3
    hbusreq = 4'b0000;
    step();
    check("park_hgrant", 32'(hgrant), 32'h1);
    check("park_state", 32'(dbg_state), 32'(PARK));
    hbusreq = 4'b0011;
    step();
    check("park_ptr_kept", 32'(hgrant), 32'h1);
    check("park_exit_state", 32'(dbg_state), 32'(GRANTED));

    // Round-robin with all requesting, owner releasing each turn
    do_reset();
    hbusreq = 4'b1111;
    step();
    check("rr_first", 32'(hgrant), 32'h2);
    prev = 4'b0010;
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      hbusreq = 4'b1111 & ~prev;
      step();
      check("rr_order", 32'(hgrant), 32'(e));
      prev = e;
    end

    // INCR4 by master 1 with master 3 waiting: handover one beat early
    do_reset();
    hbusreq = 4'b0010;
    step();
    check("incr4_grant1", 32'(hgrant), 32'h2);
    step();
    hbusreq = 4'b1010; htrans = NONSEQ; hburst = 3'd3;
    step();
    check("incr4_load_cnt", 32'(dbg_cnt), 32'd3);
    check("incr4_state", 32'(dbg_state), 32'(BURST));
    htrans = SEQ;
    step();
    check("incr4_seq1_grant", 32'(hgrant), 32'h2);
    step();
    check("incr4_seq2_grant", 32'(hgrant), 32'h8);
    check("incr4_seq2_hmaster", 32'(hmaster), 32'd1);
    step();
    check("incr4_final_hmaster", 32'(hmaster), 32'd3);
    check("incr4_final_cnt", 32'(dbg_cnt), 32'd0);
    check("incr4_final_state", 32'(dbg_state), 32'(GRANTED));
    htrans = IDLE;

    // INCR8 with a three-cycle hready stall
    do_reset();
    hbusreq = 4'b0010;
    step();
    htrans = NONSEQ; hburst = 3'd5;
    step();
    check("incr8_load_cnt", 32'(dbg_cnt), 32'd7);
    htrans = SEQ;
    step(); step();
    check("incr8_pre_stall_cnt", 32'(dbg_cnt), 32'd5);
    hready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_cnt", 32'(dbg_cnt), 32'd5);
      check("stall_hgrant", 32'(hgrant), 32'h2);
      check("stall_hmaster", 32'(hmaster), 32'd1);
    end
    hready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("incr8_cnt1", 32'(dbg_cnt), 32'd1);
    step();
    check("incr8_done_cnt", 32'(dbg_cnt), 32'd0);
    check("incr8_done_state", 32'(dbg_state), 32'(GRANTED));
    check("incr8_done_hgrant", 32'(hgrant), 32'h2);
    htrans = IDLE;

    // Locked master 2 runs two INCR4 bursts while master 0 waits
    do_reset();
    hbusreq = 4'b0100; hlock = 4'b0100;
    step();
    check("lock_grant", 32'(hgrant), 32'h4);
    check("lock_state", 32'(dbg_state), 32'(LOCKED));
    hbusreq = 4'b0101;
    for (int b = 0; b < 2; b++) begin
      htrans = NONSEQ; hburst = 3'd3;
      step();
      check("lock_nonseq_cnt", 32'(dbg_cnt), 32'd3);
      check("lock_nonseq_grant", 32'(hgrant), 32'h4);
      check("lock_nonseq_mastlock", 32'(hmastlock), 32'h1);
      htrans = SEQ;
      for (int s = 0; s < 3; s++) begin
        step();
        check("lock_seq_grant", 32'(hgrant), 32'h4);
        check("lock_seq_mastlock", 32'(hmastlock), 32'h1);
      end
      check("lock_burst_cnt", 32'(dbg_cnt), 32'd0);
    end
    htrans = IDLE; hlock = 4'b0000;
    step();
    check("unlock_grant", 32'(hgrant), 32'h1);
    check("unlock_state", 32'(dbg_state), 32'(GRANTED));
    check("unlock_mastlock", 32'(hmastlock), 32'h0);

    // Error response on beat 2 of INCR16, then reset mid-burst
    do_reset();
    hbusreq = 4'b0010;
    step();
    htrans = NONSEQ; hburst = 3'd7;
    step();
    check("incr16_load_cnt", 32'(dbg_cnt), 32'd15);
    htrans = SEQ; hresp = 1'b1;
    step();
    check("err_cnt", 32'(dbg_cnt), 32'd0);
    check("err_state", 32'(dbg_state), 32'(GRANTED));
    htrans = IDLE; hresp = 1'b0;
    step();
    check("err_keep_grant", 32'(hgrant), 32'h2);
    htrans = NONSEQ;
    step();
    htrans = SEQ;
    step();
    check("incr16_again_cnt", 32'(dbg_cnt), 32'd14);
    rst = 1'b1;
    step();
    check("midrst_hgrant", 32'(hgrant), 32'h1);
    check("midrst_hmaster", 32'(hmaster), 32'd0);
    check("midrst_cnt", 32'(dbg_cnt), 32'd0);
    check("midrst_state", 32'(dbg_state), 32'(PARK));
    step();
    check("rst_hold_hgrant", 32'(hgrant), 32'h1);
    check("rst_hold_state", 32'(dbg_state), 32'(PARK));
    rst = 1'b0; htrans = IDLE;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
